// File: rtl/change_dispenser.sv
// change_dispenser -- greedy change-return engine.
//
// Takes a balance owed and pays it out one coin at a time. The largest coin
// that still fits is always chosen, so coins come out in non-increasing order.
// Each coin is presented to the ejector over a valid/ready handshake.
//
// Parameters:
//   W         width of amount/remaining
//   COIN_HI   large coin value  (< 2^W)
//   COIN_MID  middle coin value (< COIN_HI)
//   COIN_LO   small coin value  (1, so every balance terminates)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, amount   payout request; sampled only while idle
//   coin_ready      ejector accepts the presented coin
//   abort           (CHANGE_ABORT_EN only) stop the payout early
//   coin_valid      a coin is presented on coin_sel
//   coin_sel        00 none, 01 LO, 10 MID, 11 HI
//   busy            high in every state except IDLE
//   done            one-cycle pulse when payout finishes
//   remaining       balance not yet paid out
//
// Optional feature macro: CHANGE_ABORT_EN (adds the abort input).
//
// Every output is a flop. The next-state logic computes the registered
// output values alongside the next state, so each output changes on the same
// edge as the state that it belongs to.

module change_dispenser #(
  parameter int W        = 5,
  parameter int COIN_HI  = 10,
  parameter int COIN_MID = 5,
  parameter int COIN_LO  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         coin_ready,
`ifdef CHANGE_ABORT_EN
  input  logic         abort,
`endif
  output logic         coin_valid,
  output logic [1:0]   coin_sel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remaining
);

  localparam logic [W-1:0] HI_V  = W'(COIN_HI);
  localparam logic [W-1:0] MID_V = W'(COIN_MID);
  localparam logic [W-1:0] LO_V  = W'(COIN_LO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EJECT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         valid_q, valid_d;
  logic [1:0]   sel_q, sel_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] rem_q, rem_d;

  logic         abort_w;
  logic [W-1:0] coin_val;
  logic [W-1:0] rem_after;
  logic [1:0]   pick;

`ifdef CHANGE_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Largest coin not exceeding the balance (unsigned, W bits).
  always_comb begin
    if (rem_q >= HI_V)       pick = 2'b11;
    else if (rem_q >= MID_V) pick = 2'b10;
    else                     pick = 2'b01;
  end

  // Value of the coin currently held on coin_sel.
  always_comb begin
    case (sel_q)
      2'b11:   coin_val = HI_V;
      2'b10:   coin_val = MID_V;
      2'b01:   coin_val = LO_V;
      default: coin_val = '0;
    endcase
  end

  // Saturating subtract; the greedy pick never exceeds the balance, but the
  // clamp keeps the balance from wrapping if that ever changes.
  assign rem_after = (rem_q >= coin_val) ? (rem_q - coin_val) : '0;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = amount;
          if (amount == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SELECT;
          end
        end
      end

      SELECT: begin
        if (abort_w) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          sel_d   = pick;
          valid_d = 1'b1;
          state_d = EJECT;
        end
      end

      EJECT: begin
        if (valid_q && coin_ready) begin
          // A coin accepted together with abort still counts.
          rem_d   = rem_after;
          valid_d = 1'b0;
          sel_d   = 2'b00;
          if (rem_after == '0 || abort_w) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SELECT;
          end
        end else if (abort_w) begin
          valid_d = 1'b0;
          sel_d   = 2'b00;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = 2'b00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  assign coin_valid = valid_q;
  assign coin_sel   = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign remaining  = rem_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed testbench for change_dispenser (W=5, coins 10/5/1).

module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] amount;
  logic       coin_ready;
`ifdef CHANGE_ABORT_EN
  logic       abort;
`endif
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic [4:0] remaining;

  int n_chk;
  int n_pass;

  change_dispenser #(.W(5), .COIN_HI(10), .COIN_MID(5), .COIN_LO(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .amount     (amount),
    .coin_ready (coin_ready),
`ifdef CHANGE_ABORT_EN
    .abort      (abort),
`endif
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs for amount=18 with ready high, cycles t+1..t+11.
  int e1_sel [11] = '{0, 3, 0, 2, 0, 1, 0, 1, 0, 1, 0};
  int e1_rem [11] = '{18, 18, 8, 8, 3, 3, 2, 2, 1, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n_coin;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    start = 1'b0;
    amount = '0;
    coin_ready = 1'b1;
`ifdef CHANGE_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    chk("rst_valid", coin_valid, 0);
    chk("rst_sel", coin_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rem", remaining, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // 1: amount 18 -> 11,10,01,01,01 at t+2,4,6,8,10; done t+11
    start = 1'b1; amount = 5'd18;
    step();
    start = 1'b0; amount = '0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t1_valid_c%0d", i + 1), coin_valid, (e1_sel[i] != 0) ? 1 : 0);
      chk($sformatf("t1_sel_c%0d", i + 1), coin_sel, e1_sel[i]);
      chk($sformatf("t1_rem_c%0d", i + 1), remaining, e1_rem[i]);
      chk($sformatf("t1_done_c%0d", i + 1), done, (i == 10) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", i + 1), busy, 1);
      step();
    end
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);
    chk("t1_idle_rem", remaining, 0);

    // 2: amount 0 -> done at t+1, busy one cycle, no coin
    start = 1'b1; amount = 5'd0;
    step();
    start = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 1);
    chk("t2_valid", coin_valid, 0);
    step();
    chk("t2_done_end", done, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_valid_end", coin_valid, 0);

    // 3: amount 7, ready low 4 cycles on first coin
    coin_ready = 1'b0;
    start = 1'b1; amount = 5'd7;
    step();
    start = 1'b0; amount = '0;
    chk("t3_sel_valid0", coin_valid, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) coin_ready = 1'b1;
      chk($sformatf("t3_hold_valid%0d", k), coin_valid, 1);
      chk($sformatf("t3_hold_sel%0d", k), coin_sel, 2);
      chk($sformatf("t3_hold_rem%0d", k), remaining, 7);
      step();
    end
    chk("t3_gap_valid", coin_valid, 0);
    chk("t3_gap_rem", remaining, 2);
    step();
    chk("t3_c2_sel", coin_sel, 1);
    step();
    step();
    chk("t3_c3_sel", coin_sel, 1);
    chk("t3_c3_rem", remaining, 1);
    step();
    chk("t3_done", done, 1);
    chk("t3_rem", remaining, 0);
    step();

    // 4: amount 10, second start (amount 3) in EJECT is ignored
    start = 1'b1; amount = 5'd10;
    step();
    start = 1'b0; amount = '0;
    n_done = 0;
    n_coin = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        chk("t4_sel", coin_sel, 3);
        start = 1'b1; amount = 5'd3;
      end else begin
        start = 1'b0; amount = '0;
      end
      if (done) n_done++;
      if (coin_valid) n_coin++;
      if (i == 2) chk("t4_done_at", done, 1);
      if (i == 3) chk("t4_busy_after", busy, 0);
      step();
    end
    chk("t4_done_count", n_done, 1);
    chk("t4_coin_count", n_coin, 1);
    chk("t4_rem", remaining, 0);

    // 5: reset mid-EJECT during 18
    start = 1'b1; amount = 5'd18;
    step();
    start = 1'b0; amount = '0;
    step();
    chk("t5_pre_valid", coin_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", coin_valid, 0);
    chk("t5_rst_sel", coin_sel, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rem", remaining, 0);
    step();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) n_done++;
      chk($sformatf("t5_idle_busy%0d", i), busy, 0);
      step();
    end
    chk("t5_no_done", n_done, 0);
    start = 1'b1; amount = 5'd6;
    step();
    start = 1'b0; amount = '0;
    step();
    chk("t5_c1_sel", coin_sel, 2);
    chk("t5_c1_rem", remaining, 6);
    step();
    step();
    chk("t5_c2_sel", coin_sel, 1);
    chk("t5_c2_rem", remaining, 1);
    step();
    chk("t5_done", done, 1);
    chk("t5_rem", remaining, 0);
    step();

`ifdef CHANGE_ABORT_EN
    // 6: abort together with handshake on 2nd coin of 18
    start = 1'b1; amount = 5'd18;
    step();
    start = 1'b0; amount = '0;
    step();
    chk("t6_c1_sel", coin_sel, 3);
    step();
    step();
    chk("t6_c2_sel", coin_sel, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_rem", remaining, 3);
    chk("t6_valid", coin_valid, 0);
    step();
    chk("t6_busy_end", busy, 0);
    chk("t6_rem_end", remaining, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
